// File: rtl/sockit_spi_pkg.sv
// sockit_spi_pkg
//  Shared definitions for the SPI queue path: bit positions of the queue
//  control field, the I/O mode encoding, and the arbiter state encoding.
//  No ports.
package sockit_spi_pkg;

    // Queue control field layout: [3] new, [2] lst, [1:0] iom
    localparam int CTL_NEW     = 3;
    localparam int CTL_LST     = 2;
    localparam int CTL_IOM_MSB = 1;
    localparam int CTL_IOM_LSB = 0;

    typedef enum logic [1:0] {
        IOM_3WR  = 2'd0,
        IOM_SPI  = 2'd1,
        IOM_DUAL = 2'd2,
        IOM_QUAD = 2'd3
    } iom_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sockit_spi_arb_rr.sv
// sockit_spi_arb_rr
//  Combinational round-robin picker. Searches ptr+1, ptr+2 .. ptr (mod N)
//  and returns the first requesting index.
//  Ports:
//   req  in   N    request vector
//   ptr  in   NL   index of the most recently served requester
//   idx  out  NL   picked index (0 when none)
//   any  out  1    at least one request present
module sockit_spi_arb_rr #(
    parameter int N  = 2,
    parameter int NL = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [NL-1:0] ptr,
    output logic [NL-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        // k runs 1..N so the last candidate examined is ptr itself
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = NL'(j);
            end
        end
    end

endmodule

// File: rtl/sockit_spi_arb.sv
// sockit_spi_arb
//  Round-robin arbiter sharing one SPI queue input between N requesters.
//  A grant covers a whole packet: the owner keeps the queue until it
//  transfers a segment with lst=1. Optional lock timeout is compiled in with
//  the macro SOCKIT_SPI_ARB_TMO_EN.
//
//  Handshake: a segment moves on a cycle where vld and rdy are both high;
//  vld must not depend on rdy, and the owner's req_rdy is que_rdy passed
//  straight through while locked.
//
//  Ports:
//   clk      in   1       clock
//   rst      in   1       asynchronous active-low reset
//   req_vld  in   N       requester valid
//   req_ctl  in   N*QCI   requester control, requester i at [i*QCI+:QCI]
//   req_dat  in   N*QDW   requester data, requester i at [i*QDW+:QDW]
//   req_rdy  out  N       requester ready (one-hot or zero)
//   que_vld  out  1       queue valid toward repackager
//   que_ctl  out  QCI     queue control
//   que_dat  out  QDW     queue data
//   que_rdy  in   1       queue ready from repackager
//   gnt_idx  out  NL      current owner (valid while gnt_act)
//   gnt_act  out  1       queue locked; also the FSM state (1 = LOCK)
//   tmo_err  out  1       one-cycle pulse when a lock is revoked by timeout
module sockit_spi_arb
    import sockit_spi_pkg::*;
#(
    parameter int N   = 2,
    parameter int NL  = $clog2(N),
    parameter int SDW = 8,
    parameter int QCI = 4,
    parameter int QDW = 4*SDW,
    parameter int TMO = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_vld,
    input  logic [N*QCI-1:0] req_ctl,
    input  logic [N*QDW-1:0] req_dat,
    output logic [N-1:0]     req_rdy,
    output logic             que_vld,
    output logic [QCI-1:0]   que_ctl,
    output logic [QDW-1:0]   que_dat,
    input  logic             que_rdy,
    output logic [NL-1:0]    gnt_idx,
    output logic             gnt_act,
    output logic             tmo_err
);

    arb_state_t      state, state_nxt;
    logic [NL-1:0]   ptr;
    logic [NL-1:0]   pick_idx;
    logic            pick_any;
    logic            xfer;
    logic            rls;
    logic            timeout;

    sockit_spi_arb_rr #(.N(N), .NL(NL)) u_rr (
        .req (req_vld),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign gnt_act = (state == ARB_LOCK);

    always_comb begin
        que_vld   = 1'b0;
        que_ctl   = '0;
        que_dat   = '0;
        req_rdy   = '0;
        xfer      = 1'b0;
        rls       = 1'b0;
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (pick_any) state_nxt = ARB_LOCK;
            end
            ARB_LOCK: begin
                que_vld          = req_vld[gnt_idx];
                que_ctl          = req_ctl[gnt_idx*QCI +: QCI];
                que_dat          = req_dat[gnt_idx*QDW +: QDW];
                req_rdy[gnt_idx] = que_rdy;
                xfer             = que_vld & que_rdy;
                rls              = (xfer & que_ctl[CTL_LST]) | timeout;
                if (rls) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            ptr     <= NL'(N-1);
            gnt_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && pick_any) gnt_idx <= pick_idx;
            // Released owner becomes the lowest priority for the next search
            if (rls) ptr <= gnt_idx;
        end
    end

`ifdef SOCKIT_SPI_ARB_TMO_EN
    localparam int CW = $clog2(TMO+1);
    logic [CW-1:0] cnt;

    // cnt holds the number of stalled LOCK cycles already elapsed, so the
    // TMO-th consecutive stall is the one that releases the lock.
    assign timeout = (state == ARB_LOCK) && !xfer && (cnt == CW'(TMO-1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            tmo_err <= 1'b0;
        end else begin
            tmo_err <= timeout;
            if (state == ARB_IDLE || xfer) cnt <= '0;
            else                           cnt <= cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_sockit_spi_arb.sv
// tb_sockit_spi_arb
//  Directed bench for sockit_spi_arb with N=2, SDW=8, TMO=16.
module tb_sockit_spi_arb;

    localparam int N   = 2;
    localparam int NL  = 1;
    localparam int QCI = 4;
    localparam int QDW = 32;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_vld;
    logic [N*QCI-1:0] req_ctl;
    logic [N*QDW-1:0] req_dat;
    logic [N-1:0]     req_rdy;
    logic             que_vld;
    logic [QCI-1:0]   que_ctl;
    logic [QDW-1:0]   que_dat;
    logic             que_rdy;
    logic [NL-1:0]    gnt_idx;
    logic             gnt_act;
    logic             tmo_err;

    int n_vec = 0;
    int n_err = 0;

    sockit_spi_arb #(.N(N), .SDW(8), .QCI(QCI), .QDW(QDW), .TMO(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_ctl (req_ctl),
        .req_dat (req_dat),
        .req_rdy (req_rdy),
        .que_vld (que_vld),
        .que_ctl (que_ctl),
        .que_dat (que_dat),
        .que_rdy (que_rdy),
        .gnt_idx (gnt_idx),
        .gnt_act (gnt_act),
        .tmo_err (tmo_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] c, input logic [31:0] d);
        req_vld[i]         = v;
        req_ctl[i*QCI+:QCI] = c;
        req_dat[i*QDW+:QDW] = d;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        req_vld = '0;
        req_ctl = '0;
        req_dat = '0;
        que_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // tests
    task automatic test_reset();
        rst     = 1'b0;
        req_vld = '1;
        req_ctl = '0;
        req_dat = '1;
        que_rdy = 1'b1;
        @(negedge clk);
        n_vec++;
        if (gnt_act !== 1'b0 || que_vld !== 1'b0 || req_rdy !== 2'b00 || tmo_err !== 1'b0 ||
            gnt_idx !== 1'b0 || que_dat !== 32'h0 || que_ctl !== 4'h0) begin
            n_err++;
            $display("FAIL reset: act=%b vld=%b rdy=%b tmo=%b idx=%0d dat=%h ctl=%h, want all 0",
                     gnt_act, que_vld, req_rdy, tmo_err, gnt_idx, que_dat, que_ctl);
        end
    endtask

    task automatic test_single();
        do_reset();
        que_rdy = 1'b1;
        set_req(0, 1'b1, 4'b0000, 32'hA000_0000);
        @(negedge clk);
        n_vec++;
        if (gnt_act !== 1'b0 || que_vld !== 1'b0 || req_rdy !== 2'b00) begin
            n_err++;
            $display("FAIL single_idle: act=%b vld=%b rdy=%b, want 0 0 00", gnt_act, que_vld, req_rdy);
        end
        for (int s = 0; s < 3; s++) begin
            step();
            set_req(0, 1'b1, (s == 2) ? 4'b0100 : 4'b0000, 32'hA000_0000 + s);
            @(negedge clk);
            n_vec++;
            if (gnt_act !== 1'b1 || gnt_idx !== 1'b0 || que_vld !== 1'b1 || req_rdy !== 2'b01 ||
                que_dat !== 32'hA000_0000 + s || que_ctl !== ((s == 2) ? 4'b0100 : 4'b0000)) begin
                n_err++;
                $display("FAIL single_seg%0d: act=%b idx=%0d vld=%b rdy=%b dat=%h ctl=%h, want 1 0 1 01 %h",
                         s, gnt_act, gnt_idx, que_vld, req_rdy, que_dat, que_ctl, 32'hA000_0000 + s);
            end
        end
        step();
        set_req(0, 1'b0, 4'b0000, 32'h0);
        @(negedge clk);
        n_vec++;
        if (gnt_act !== 1'b0 || que_vld !== 1'b0 || que_dat !== 32'h0) begin
            n_err++;
            $display("FAIL single_end: act=%b vld=%b dat=%h, want 0 0 0", gnt_act, que_vld, que_dat);
        end
    endtask

    task automatic test_rr();
        do_reset();
        que_rdy = 1'b1;
        set_req(0, 1'b1, 4'b0100, 32'hB000_0000);
        set_req(1, 1'b1, 4'b0100, 32'hB111_1111);
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            n_vec++;
            if (gnt_act !== 1'b0 || req_rdy !== 2'b00) begin
                n_err++;
                $display("FAIL rr_idle%0d: act=%b rdy=%b, want 0 00", p, gnt_act, req_rdy);
            end
            step();
            @(negedge clk);
            n_vec++;
            if (gnt_act !== 1'b1 || gnt_idx !== NL'(p % 2) || req_rdy !== 2'(1 << (p % 2)) ||
                que_dat !== ((p % 2) ? 32'hB111_1111 : 32'hB000_0000)) begin
                n_err++;
                $display("FAIL rr_grant%0d: act=%b idx=%0d rdy=%b dat=%h, want idx %0d",
                         p, gnt_act, gnt_idx, req_rdy, que_dat, p % 2);
            end
            step();
            @(negedge clk);
        end
    endtask

    task automatic test_owner_gap();
        do_reset();
        que_rdy = 1'b1;
        set_req(0, 1'b1, 4'b0000, 32'hC000_0000);
        set_req(1, 1'b1, 4'b0100, 32'hD000_0000);
        step();
        @(negedge clk);
        n_vec++;
        if (gnt_act !== 1'b1 || gnt_idx !== 1'b0 || que_dat !== 32'hC000_0000) begin
            n_err++;
            $display("FAIL gap_first: act=%b idx=%0d dat=%h, want 1 0 c0000000", gnt_act, gnt_idx, que_dat);
        end
        step();
        set_req(0, 1'b0, 4'b0000, 32'hC000_0001);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if (que_vld !== 1'b0 || gnt_act !== 1'b1 || gnt_idx !== 1'b0 || req_rdy !== 2'b01) begin
                n_err++;
                $display("FAIL gap_hold%0d: vld=%b act=%b idx=%0d rdy=%b, want 0 1 0 01",
                         k, que_vld, gnt_act, gnt_idx, req_rdy);
            end
            step();
        end
        set_req(0, 1'b1, 4'b0100, 32'hC000_0001);
        @(negedge clk);
        n_vec++;
        if (que_vld !== 1'b1 || gnt_idx !== 1'b0 || que_dat !== 32'hC000_0001) begin
            n_err++;
            $display("FAIL gap_resume: vld=%b idx=%0d dat=%h, want 1 0 c0000001", que_vld, gnt_idx, que_dat);
        end
        step();
        step();
        @(negedge clk);
        n_vec++;
        if (gnt_act !== 1'b1 || gnt_idx !== 1'b1 || que_dat !== 32'hD000_0000) begin
            n_err++;
            $display("FAIL gap_next: act=%b idx=%0d dat=%h, want 1 1 d0000000", gnt_act, gnt_idx, que_dat);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        que_rdy = 1'b0;
        set_req(0, 1'b1, 4'b0000, 32'hE000_0000);
        set_req(1, 1'b1, 4'b0100, 32'hE111_0000);
        step();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_vec++;
            if (gnt_act !== 1'b1 || gnt_idx !== 1'b0 || que_vld !== 1'b1 ||
                que_dat !== 32'hE000_0000 || req_rdy !== 2'b00) begin
                n_err++;
                $display("FAIL bp_stall%0d: act=%b idx=%0d vld=%b dat=%h rdy=%b, want 1 0 1 e0000000 00",
                         k, gnt_act, gnt_idx, que_vld, que_dat, req_rdy);
            end
            step();
        end
        set_req(0, 1'b1, 4'b0100, 32'hE000_0000);
        que_rdy = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req_rdy !== 2'b01 || que_dat !== 32'hE000_0000) begin
            n_err++;
            $display("FAIL bp_release: rdy=%b dat=%h, want 01 e0000000", req_rdy, que_dat);
        end
        step();
        @(negedge clk);
        n_vec++;
        if (gnt_act !== 1'b0) begin
            n_err++;
            $display("FAIL bp_idle: act=%b, want 0", gnt_act);
        end
        step();
        @(negedge clk);
        n_vec++;
        if (gnt_act !== 1'b1 || gnt_idx !== 1'b1) begin
            n_err++;
            $display("FAIL bp_next: act=%b idx=%0d, want 1 1", gnt_act, gnt_idx);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        que_rdy = 1'b0;
        set_req(0, 1'b1, 4'b0000, 32'hF000_0000);
        set_req(1, 1'b1, 4'b0100, 32'hF111_0000);
`ifdef SOCKIT_SPI_ARB_TMO_EN
        for (int k = 1; k <= 16; k++) begin
            step();
            @(negedge clk);
            n_vec++;
            if (gnt_act !== 1'b1 || gnt_idx !== 1'b0 || tmo_err !== 1'b0) begin
                n_err++;
                $display("FAIL tmo_lock%0d: act=%b idx=%0d tmo=%b, want 1 0 0", k, gnt_act, gnt_idx, tmo_err);
            end
        end
        step();
        @(negedge clk);
        n_vec++;
        if (gnt_act !== 1'b0 || tmo_err !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_pulse: act=%b tmo=%b, want 0 1", gnt_act, tmo_err);
        end
        step();
        @(negedge clk);
        n_vec++;
        if (gnt_act !== 1'b1 || gnt_idx !== 1'b1 || tmo_err !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_regrant: act=%b idx=%0d tmo=%b, want 1 1 0", gnt_act, gnt_idx, tmo_err);
        end
`else
        for (int k = 1; k <= 20; k++) begin
            step();
            @(negedge clk);
            n_vec++;
            if (gnt_act !== 1'b1 || gnt_idx !== 1'b0 || tmo_err !== 1'b0) begin
                n_err++;
                $display("FAIL hold_lock%0d: act=%b idx=%0d tmo=%b, want 1 0 0", k, gnt_act, gnt_idx, tmo_err);
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        que_rdy = 1'b1;
        set_req(0, 1'b1, 4'b0100, 32'h1000_0000);
        set_req(1, 1'b1, 4'b0000, 32'h2000_0000);
        step();
        step();
        step();
        @(negedge clk);
        n_vec++;
        if (gnt_act !== 1'b1 || gnt_idx !== 1'b1 || que_vld !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre: act=%b idx=%0d vld=%b, want 1 1 1", gnt_act, gnt_idx, que_vld);
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (gnt_act !== 1'b0 || que_vld !== 1'b0 || req_rdy !== 2'b00) begin
            n_err++;
            $display("FAIL rstmid_async: act=%b vld=%b rdy=%b, want 0 0 00", gnt_act, que_vld, req_rdy);
        end
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (gnt_act !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_idle: act=%b, want 0", gnt_act);
        end
        step();
        @(negedge clk);
        n_vec++;
        if (gnt_act !== 1'b1 || gnt_idx !== 1'b0 || que_dat !== 32'h1000_0000) begin
            n_err++;
            $display("FAIL rstmid_restart: act=%b idx=%0d dat=%h, want 1 0 10000000", gnt_act, gnt_idx, que_dat);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_owner_gap();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
